pipe_hazard_ctrl: RTL and testbench

//  Hazard/sequencing controller for the 5-stage pipeline (IF/ID/EX/MEM/WB). Drives the stall and

---
 rtl/pipe_hazard_ctrl.sv | 135 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage pipeline: EX-stage forwarding selects,
// load-use and branch stall/flush, data-memory wait FSM with timeout, and a stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int unsigned TMO_CYCLES = 16,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_IfId,
    input  logic [4:0]       rs2_IfId,
    input  logic [4:0]       rs1_IdEx,
    input  logic [4:0]       rs2_IdEx,
    input  logic [4:0]       rd_IdEx,
    input  logic             reg_write_IdEx,
    input  logic [1:0]       result_src_IdEx,
    input  logic [4:0]       rd_ExMem,
    input  logic             reg_write_ExMem,
    input  logic [4:0]       rd_MemWB,
    input  logic             reg_write_MemWB,
    input  logic             pc_src_E,
    input  logic             mreq_ExMem,
    input  logic             mem_ack,
    output logic [1:0]       forward_rs1,
    output logic [1:0]       forward_rs2,
    output logic             stall_pc,
    output logic             stall_IfId,
    output logic             stall_IdEx,
    output logic             stall_ExMem,
    output logic             stall_MemWB,
    output logic             flush_IfId,
    output logic             flush_IdEx,
    output logic             flush_ExMem,
    output logic             flush_MemWB,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int unsigned TW = $clog2(TMO_CYCLES + 1);
    localparam logic [TW-1:0] TMO_VAL = TW'(TMO_CYCLES);

    typedef enum logic [1:0] {StIdle, StWait, StErr} state_e;

    state_e           state_q, state_d;
    logic [TW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_count_q;
    logic             fwd_mem1, fwd_mem2, fwd_wb1, fwd_wb2;
    logic             lu, ms;

    assign fwd_mem1 = reg_write_ExMem && (rd_ExMem != 5'd0) && (rd_ExMem == rs1_IdEx);
    assign fwd_mem2 = reg_write_ExMem && (rd_ExMem != 5'd0) && (rd_ExMem == rs2_IdEx);
    assign fwd_wb1  = reg_write_MemWB && (rd_MemWB != 5'd0) && (rd_MemWB == rs1_IdEx);
    assign fwd_wb2  = reg_write_MemWB && (rd_MemWB != 5'd0) && (rd_MemWB == rs2_IdEx);

    assign lu = (result_src_IdEx == 2'b01) && reg_write_IdEx && (rd_IdEx != 5'd0) &&
                ((rd_IdEx == rs1_IfId) || (rd_IdEx == rs2_IfId));
    // ERR keeps the pipe frozen even after the request goes away.
    assign ms = (mreq_ExMem && !mem_ack) || (state_q == StErr);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (ms) begin
                    state_d = StWait;
                    cnt_d   = TW'(1);
                end
            end
            StWait: begin
                if (mem_ack || !mreq_ExMem) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_VAL) begin
                    state_d = StErr;
                end else begin
                    cnt_d = cnt_q + TW'(1);
                end
            end
            StErr:   state_d = StErr;
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase
    end

    // Outputs are gated by rst so they fall to idle values the moment reset asserts.
    always_comb begin
        forward_rs1 = 2'b00;
        forward_rs2 = 2'b00;
        stall_pc    = 1'b0;
        stall_IfId  = 1'b0;
        stall_IdEx  = 1'b0;
        stall_ExMem = 1'b0;
        stall_MemWB = 1'b0;
        flush_IfId  = 1'b0;
        flush_IdEx  = 1'b0;
        flush_ExMem = 1'b0;
        flush_MemWB = 1'b0;
        if (rst) begin
            forward_rs1 = fwd_mem1 ? 2'b01 : (fwd_wb1 ? 2'b10 : 2'b00);
            forward_rs2 = fwd_mem2 ? 2'b01 : (fwd_wb2 ? 2'b10 : 2'b00);
            if (ms) begin
                stall_pc    = 1'b1;
                stall_IfId  = 1'b1;
                stall_IdEx  = 1'b1;
                stall_ExMem = 1'b1;
                flush_MemWB = 1'b1;
            end else begin
                stall_pc   = lu && !pc_src_E;
                stall_IfId = lu && !pc_src_E;
                flush_IfId = pc_src_E;
                flush_IdEx = pc_src_E || lu;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= StIdle;
            cnt_q         <= '0;
            stall_count_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall_pc && (stall_count_q != {CNT_W{1'b1}})) begin
                stall_count_q <= stall_count_q + CNT_W'(1);
            end
        end
    end

    assign mem_timeout = (state_q == StErr);
    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed self-checking bench for pipe_hazard_ctrl (TMO_CYCLES=4, 4-bit stall counter).
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] rs1_IfId, rs2_IfId, rs1_IdEx, rs2_IdEx, rd_IdEx, rd_ExMem, rd_MemWB;
    logic       reg_write_IdEx, reg_write_ExMem, reg_write_MemWB;
    logic [1:0] result_src_IdEx;
    logic       pc_src_E, mreq_ExMem, mem_ack;
    logic [1:0] forward_rs1, forward_rs2;
    logic       stall_pc, stall_IfId, stall_IdEx, stall_ExMem, stall_MemWB;
    logic       flush_IfId, flush_IdEx, flush_ExMem, flush_MemWB;
    logic       mem_timeout;
    logic [3:0] stall_count;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.TMO_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .rs1_IfId(rs1_IfId), .rs2_IfId(rs2_IfId),
        .rs1_IdEx(rs1_IdEx), .rs2_IdEx(rs2_IdEx), .rd_IdEx(rd_IdEx),
        .reg_write_IdEx(reg_write_IdEx), .result_src_IdEx(result_src_IdEx),
        .rd_ExMem(rd_ExMem), .reg_write_ExMem(reg_write_ExMem),
        .rd_MemWB(rd_MemWB), .reg_write_MemWB(reg_write_MemWB),
        .pc_src_E(pc_src_E), .mreq_ExMem(mreq_ExMem), .mem_ack(mem_ack),
        .forward_rs1(forward_rs1), .forward_rs2(forward_rs2),
        .stall_pc(stall_pc), .stall_IfId(stall_IfId), .stall_IdEx(stall_IdEx),
        .stall_ExMem(stall_ExMem), .stall_MemWB(stall_MemWB),
        .flush_IfId(flush_IfId), .flush_IdEx(flush_IdEx),
        .flush_ExMem(flush_ExMem), .flush_MemWB(flush_MemWB),
        .mem_timeout(mem_timeout), .stall_count(stall_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        rs1_IfId = 0; rs2_IfId = 0; rs1_IdEx = 0; rs2_IdEx = 0; rd_IdEx = 0;
        rd_ExMem = 0; rd_MemWB = 0; reg_write_IdEx = 0; reg_write_ExMem = 0;
        reg_write_MemWB = 0; result_src_IdEx = 0; pc_src_E = 0; mreq_ExMem = 0; mem_ack = 0;
    endtask

    initial begin
        // Reset with every hazard input active: outputs must still be idle.
        rst = 1'b0;
        clear_inputs();
        rd_ExMem = 5; reg_write_ExMem = 1; rs1_IdEx = 5; pc_src_E = 1; mreq_ExMem = 1;
        result_src_IdEx = 2'b01; reg_write_IdEx = 1; rd_IdEx = 6; rs2_IfId = 6;
        #12;
        chk("rst_fwd1", forward_rs1, 2'b00);
        chk("rst_stall_pc", stall_pc, 0);
        chk("rst_flush_ifid", flush_IfId, 0);
        chk("rst_flush_memwb", flush_MemWB, 0);
        chk("rst_timeout", mem_timeout, 0);
        chk("rst_count", stall_count, 0);
        clear_inputs();
        tick();
        rst = 1'b1;
        #1;

        // Forwarding: MEM over WB, then WB alone, then x0 never forwards.
        rd_ExMem = 5; reg_write_ExMem = 1; rs1_IdEx = 5;
        rd_MemWB = 5; reg_write_MemWB = 1;
        #1 chk("fwd_mem", forward_rs1, 2'b01);
        chk("fwd_rs2_none", forward_rs2, 2'b00);
        reg_write_ExMem = 0; rs2_IdEx = 5;
        #1 chk("fwd_wb_rs1", forward_rs1, 2'b10);
        chk("fwd_wb_rs2", forward_rs2, 2'b10);
        rd_ExMem = 0; rd_MemWB = 0; reg_write_ExMem = 1; rs1_IdEx = 0; rs2_IdEx = 0;
        #1 chk("fwd_x0_rs1", forward_rs1, 2'b00);
        chk("fwd_x0_rs2", forward_rs2, 2'b00);
        chk("fwd_no_stall", stall_pc, 0);
        clear_inputs();

        // Load-use on rs2: one stalled cycle.
        result_src_IdEx = 2'b01; reg_write_IdEx = 1; rd_IdEx = 6; rs2_IfId = 6;
        #1 chk("lu_stall_pc", stall_pc, 1);
        chk("lu_stall_ifid", stall_IfId, 1);
        chk("lu_flush_idex", flush_IdEx, 1);
        chk("lu_stall_idex", stall_IdEx, 0);
        chk("lu_flush_ifid", flush_IfId, 0);
        tick();
        clear_inputs();
        #1 chk("lu_count", stall_count, 1);
        chk("lu_released", stall_pc, 0);
        result_src_IdEx = 2'b01; reg_write_IdEx = 1; rd_IdEx = 0; rs1_IfId = 0;
        #1 chk("lu_rd0", stall_pc, 0);
        clear_inputs();

        // Branch taken wins over a load-use match.
        pc_src_E = 1; result_src_IdEx = 2'b01; reg_write_IdEx = 1; rd_IdEx = 7; rs1_IfId = 7;
        #1 chk("br_flush_ifid", flush_IfId, 1);
        chk("br_flush_idex", flush_IdEx, 1);
        chk("br_stall_pc", stall_pc, 0);
        tick();
        clear_inputs();
        #1 chk("br_count", stall_count, 1);

        // Memory wait: 3 stalled cycles, branch flush deferred until release.
        mreq_ExMem = 1; pc_src_E = 1;
        #1 chk("mw_stall_pc", stall_pc, 1);
        chk("mw_stall_exmem", stall_ExMem, 1);
        chk("mw_stall_memwb", stall_MemWB, 0);
        chk("mw_flush_memwb", flush_MemWB, 1);
        chk("mw_flush_ifid", flush_IfId, 0);
        chk("mw_flush_idex", flush_IdEx, 0);
        tick();
        chk("mw_wait1", stall_IdEx, 1);
        tick();
        chk("mw_wait2", stall_IfId, 1);
        tick();
        mem_ack = 1;
        #1 chk("mw_ack_stall", stall_pc, 0);
        chk("mw_ack_flush_memwb", flush_MemWB, 0);
        chk("mw_ack_branch", flush_IfId, 1);
        tick();
        clear_inputs();
        #1 chk("mw_count", stall_count, 4);
        chk("mw_idle", stall_pc, 0);

        // Same-cycle request and ack: no stall.
        mreq_ExMem = 1; mem_ack = 1;
        #1 chk("zero_wait", stall_pc, 0);
        tick();
        clear_inputs();

        // Request withdrawn during WAIT: back to idle, no error.
        mreq_ExMem = 1;
        tick();
        tick();
        mreq_ExMem = 0;
        #1 chk("withdraw_stall", stall_pc, 0);
        tick();
        chk("withdraw_timeout", mem_timeout, 0);
        chk("withdraw_count", stall_count, 6);

        // Saturation: counter 6 -> 15 after 9 stalled cycles, then stays.
        result_src_IdEx = 2'b01; reg_write_IdEx = 1; rd_IdEx = 9; rs1_IfId = 9;
        for (int i = 0; i < 9; i++) tick();
        chk("sat_reach", stall_count, 15);
        for (int i = 0; i < 3; i++) tick();
        chk("sat_hold", stall_count, 15);
        clear_inputs();

        // Timeout: idle cycle + 4 WAIT cycles without ack, then ERR.
        mreq_ExMem = 1;
        for (int i = 0; i < 4; i++) tick();
        chk("tmo_not_yet", mem_timeout, 0);
        tick();
        chk("tmo_set", mem_timeout, 1);
        mreq_ExMem = 0; pc_src_E = 1;
        #1 chk("tmo_stall_held", stall_pc, 1);
        chk("tmo_flush_ifid", flush_IfId, 0);
        tick();
        chk("tmo_sticky", mem_timeout, 1);
        rst = 1'b0;
        #1 chk("tmo_rst_stall", stall_pc, 0);
        chk("tmo_rst_flag", mem_timeout, 0);
        chk("tmo_rst_count", stall_count, 0);
        clear_inputs();
        tick();
        rst = 1'b1;

        // Reset asserted in the middle of a WAIT.
        mreq_ExMem = 1;
        tick();
        tick();
        chk("mid_wait_stall", stall_pc, 1);
        rst = 1'b0;
        #1 chk("mid_rst_stall", stall_pc, 0);
        chk("mid_rst_flush_memwb", flush_MemWB, 0);
        chk("mid_rst_count", stall_count, 0);
        clear_inputs();
        tick();
        rst = 1'b1;
        tick();
        chk("post_rst_stall", stall_pc, 0);
        chk("post_rst_timeout", mem_timeout, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
